// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and the main opcode decoder.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] HALT   = 7'b1111111;

  localparam int unsigned DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard: a LW in EX writes a register the ID instruction reads.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_uses_rs1,
  input  logic              i_id_uses_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_mem_read,
  output logic              o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  // x0 is never a real producer, so a load into x0 cannot create a hazard
  assign o_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage enables/flushes for load-use stalls,
// redirect flushes, data-memory waits and the HALT drain.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_en,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  ctrl_state_e      r_state;
  ctrl_state_e      w_state_nxt;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_mem_wait;
  logic w_stall_inc;
  logic w_flush_inc;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_pipe_en;
  logic w_halted;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_load_use    (w_load_use)
  );

  assign w_mem_wait = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_nxt  = r_drain_cnt;
    w_pc_write   = 1'b0;
    w_ifid_write = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_pipe_en    = 1'b0;
    w_halted     = 1'b0;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_mem_wait) begin
          // full freeze: all enables stay at their 0 defaults
        end else if (ex_redirect) begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
          w_pipe_en    = 1'b1;
          w_flush_inc  = 1'b1;
        end else if (w_load_use) begin
          w_idex_flush = 1'b1;
          w_pipe_en    = 1'b1;
          w_stall_inc  = 1'b1;
        end else if (id_halt) begin
          w_ifid_write = 1'b1;
          w_ifid_flush = 1'b1;
          w_pipe_en    = 1'b1;
          w_state_nxt  = DRAIN;
          w_drain_nxt  = DRAIN_LOAD;
        end else begin
          w_pc_write   = 1'b1;
          w_ifid_write = 1'b1;
          w_pipe_en    = 1'b1;
        end
      end
      DRAIN: begin
        w_ifid_flush = 1'b1;
        w_ifid_write = !w_mem_wait;
        w_pipe_en    = !w_mem_wait;
        if (!w_mem_wait) begin
          if (r_drain_cnt == '0) begin
            w_state_nxt = HALTED;
          end else begin
            w_drain_nxt = r_drain_cnt - 1'b1;
          end
        end
      end
      HALTED: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Reset overrides the decoded controls so nothing loads while rst_n is low
  assign pc_write   = rst_n && w_pc_write;
  assign ifid_write = rst_n && w_ifid_write;
  assign ifid_flush = rst_n && w_ifid_flush;
  assign idex_flush = rst_n && w_idex_flush;
  assign pipe_en    = rst_n && w_pipe_en;
  assign halted     = rst_n && w_halted;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: cycle-level behavioural model plus directed scenarios.
module tb_pipe_ctrl;

  localparam int unsigned DRAIN_CYCLES = 4;
  localparam int unsigned REG_AW       = 5;
  localparam int unsigned CNT_W        = 16;
  localparam int          CNT_MAX      = 65535;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REG_AW-1:0] id_rs1 = '0;
  logic [REG_AW-1:0] id_rs2 = '0;
  logic              id_uses_rs1 = 1'b0;
  logic              id_uses_rs2 = 1'b0;
  logic              id_halt = 1'b0;
  logic [REG_AW-1:0] ex_rd = '0;
  logic              ex_mem_read = 1'b0;
  logic              ex_redirect = 1'b0;
  logic              mem_req = 1'b0;
  logic              mem_ready = 1'b1;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_flush;
  logic              pipe_en;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .REG_AW      (REG_AW),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_halt     (id_halt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .pipe_en     (pipe_en),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: core is stopped, or draining with a count of advancing cycles left,
  // or running normally; counters are plain integers clamped at CNT_MAX.
  bit m_stopped;
  bit m_draining;
  int m_left;
  int m_stalls;
  int m_flushes;

  function automatic bit hazard();
    return ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit waiting();
    return mem_req && !mem_ready;
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en, halted}
  function automatic logic [5:0] expect_ctl();
    if (!rst_n || (m_stopped && !m_draining && 0)) return 6'b000000;
    if (m_stopped) return 6'b000001;
    if (m_draining) return {1'b0, !waiting(), 1'b1, 1'b0, !waiting(), 1'b0};
    if (waiting()) return 6'b000000;
    if (ex_redirect) return 6'b111110;
    if (hazard()) return 6'b000110;
    if (id_halt) return 6'b011010;
    return 6'b110010;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stopped  <= 1'b0;
      m_draining <= 1'b0;
      m_left     <= 0;
      m_stalls   <= 0;
      m_flushes  <= 0;
    end else if (m_stopped) begin
      m_stopped <= 1'b1;
    end else if (m_draining) begin
      if (!waiting()) begin
        if (m_left == 0) begin
          m_draining <= 1'b0;
          m_stopped  <= 1'b1;
        end else begin
          m_left <= m_left - 1;
        end
      end
    end else if (!waiting()) begin
      if (ex_redirect) m_flushes <= (m_flushes < CNT_MAX) ? m_flushes + 1 : m_flushes;
      else if (hazard()) m_stalls <= (m_stalls < CNT_MAX) ? m_stalls + 1 : m_stalls;
      else if (id_halt) begin
        m_draining <= 1'b1;
        m_left     <= DRAIN_CYCLES - 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] act_ctl;
    logic [5:0] exp_ctl;
    act_ctl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en, halted};
    exp_ctl = expect_ctl();
    checks++;
    if (act_ctl !== exp_ctl || stall_cnt !== CNT_W'(m_stalls) || flush_cnt !== CNT_W'(m_flushes)) begin
      failures++;
      $display("FAIL model t=%0t ctl act=%b exp=%b stall act=%0d exp=%0d flush act=%0d exp=%0d",
               $time, act_ctl, exp_ctl, stall_cnt, m_stalls, flush_cnt, m_flushes);
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_halt = 1'b0; ex_rd = '0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic load_use_rs1(input int rd);
    ex_mem_read = 1'b1; ex_rd = REG_AW'(rd);
    id_rs1 = REG_AW'(rd); id_uses_rs1 = 1'b1;
  endtask

  initial begin
    idle();
    mid();
    lit("reset_pc_write", pc_write, 0);
    lit("reset_halted", halted, 0);
    lit("reset_pipe_en", pipe_en, 0);
    step();
    rst_n = 1'b1;
    mid();
    lit("run_pc_write", pc_write, 1);

    // load-use on rs1
    step(); load_use_rs1(5);
    mid();
    lit("lu_pc_write", pc_write, 0);
    lit("lu_ifid_write", ifid_write, 0);
    lit("lu_idex_flush", idex_flush, 1);
    step(); idle();
    mid();
    lit("lu_stall_cnt", stall_cnt, 1);
    lit("lu_after_pc_write", pc_write, 1);

    // load into x0: no hazard
    step(); load_use_rs1(0);
    mid();
    lit("x0_pc_write", pc_write, 1);
    step(); idle();
    mid();
    lit("x0_stall_cnt", stall_cnt, 1);

    // hazard through rs2 only
    step(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
    mid();
    lit("rs2_idex_flush", idex_flush, 1);
    step(); idle();

    // redirect beats load-use
    step(); load_use_rs1(7); ex_redirect = 1'b1;
    mid();
    lit("rd_pc_write", pc_write, 1);
    lit("rd_ifid_flush", ifid_flush, 1);
    lit("rd_idex_flush", idex_flush, 1);
    step(); idle();
    mid();
    lit("rd_flush_cnt", flush_cnt, 1);
    lit("rd_stall_cnt", stall_cnt, 2);

    // memory wait of 3 cycles during load-use
    step(); load_use_rs1(3); mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      lit("mw_pc_write", pc_write, 0);
      lit("mw_pipe_en", pipe_en, 0);
      lit("mw_idex_flush", idex_flush, 0);
      step();
    end
    mem_ready = 1'b1;
    mid();
    lit("mw_bubble", idex_flush, 1);
    step(); idle();
    mid();
    lit("mw_stall_cnt", stall_cnt, 3);

    // HALT with no waits: 4 drain cycles, halted on the 5th
    step(); id_halt = 1'b1;
    mid();
    lit("halt_pc_write", pc_write, 0);
    lit("halt_ifid_flush", ifid_flush, 1);
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) ex_redirect = 1'b1;
      mid();
      lit("drain_halted", halted, 0);
      lit("drain_pipe_en", pipe_en, 1);
      step(); idle();
    end
    mid();
    lit("halted_set", halted, 1);
    lit("halted_pc_write", pc_write, 0);
    lit("drain_redirect_ignored", flush_cnt, 1);
    step();
    mid();
    lit("halted_sticky", halted, 1);

    // reset pulse while halted
    rst_n = 1'b0;
    #1;
    lit("rst_halted", halted, 0);
    lit("rst_stall_cnt", stall_cnt, 0);
    lit("rst_flush_cnt", flush_cnt, 0);
    step();
    rst_n = 1'b1;
    mid();
    lit("rst_release_pc_write", pc_write, 1);

    // HALT with a 2-cycle wait in the second drain cycle: halted 2 cycles later
    step(); id_halt = 1'b1;
    step(); idle();
    for (int i = 0; i < 6; i++) begin
      if (i == 1 || i == 2) begin mem_req = 1'b1; mem_ready = 1'b0; end
      mid();
      lit("drainw_halted", halted, 0);
      if (i == 1) lit("drainw_pipe_en", pipe_en, 0);
      step(); idle();
    end
    mid();
    lit("drainw_halted_set", halted, 1);

    // saturation of flush_cnt
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 0; i < CNT_MAX + 4; i++) step();
    mid();
    lit("flush_saturate", flush_cnt, CNT_MAX);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core. It consumes decoded control from ID/EX/MEM and produces per-stage enables and flushes. It handles load-use stalls, taken-branch/jump flushes, data-memory wait states and the HALT drain sequence. It sits beside the main opcode decoder and drives the IF/ID, ID/EX, EX/MEM and MEM/WB register controls plus the PC write enable.

Parameters:
DRAIN_CYCLES, 4, number of advancing cycles after HALT leaves ID before the pipeline is empty (EX, MEM, WB, plus 1 margin).
REG_AW, 5, register-index width.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
id_rs1  in  REG_AW  rs1 index of the instruction in ID.
id_rs2  in  REG_AW  rs2 index of the instruction in ID.
id_uses_rs1  in  1  ID instruction reads rs1.
id_uses_rs2  in  1  ID instruction reads rs2 (R-type, SW, BR only).
id_halt  in  1  ID instruction is HALT (opcode 7'b1111111).
ex_rd  in  REG_AW  destination of the instruction in EX.
ex_mem_read  in  1  EX instruction is LW.
ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
mem_req  in  1  MEM instruction accesses data memory (MemRead|MemWrite).
mem_ready  in  1  data memory completes the access this cycle.
pc_write  out  1  PC register load enable.
ifid_write  out  1  IF/ID load enable.
ifid_flush  out  1  IF/ID loads a bubble.
idex_flush  out  1  ID/EX loads a bubble.
pipe_en  out  1  global enable for ID/EX, EX/MEM and MEM/WB.
halted  out  1  core stopped.
stall_cnt  out  CNT_W  saturating count of load-use stall cycles.
flush_cnt  out  CNT_W  saturating count of redirect flushes.

Behaviour:
- State register, encoding {RUN, DRAIN, HALTED}. Reset: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0.
- While rst_n=0, force pc_write=ifid_write=pipe_en=0, flushes=0 and halted=0.
- All enables and flushes are combinational from state plus inputs. Only the state, drain counter and perf counters are registered.
- Define mem_wait = mem_req & ~mem_ready.
- Define load_use = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, priority highest first:
  1. mem_wait: pc_write=0, ifid_write=0, pipe_en=0, no flushes. The whole pipe freezes and nothing else is evaluated.
  2. ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, pipe_en=1. Any simultaneous load_use or id_halt is ignored because it is wrong-path. flush_cnt increments.
  3. load_use: pc_write=0, ifid_write=0, idex_flush=1, pipe_en=1. Exactly 1 bubble per load-use. stall_cnt increments.
  4. id_halt: pc_write=0, ifid_flush=1, pipe_en=1. The HALT itself advances into EX. Next state is DRAIN with drain counter=DRAIN_CYCLES-1.
  5. Otherwise: pc_write=ifid_write=pipe_en=1, no flushes.
- DRAIN: pc_write=0, ifid_flush=1, pipe_en=~mem_wait, ifid_write=~mem_wait.
  - The counter decrements only on cycles with mem_wait=0.
  - When the counter is 0 and mem_wait=0, next state is HALTED.
  - ex_redirect is ignored, since only older instructions remain.
- HALTED: all enables=0, flushes=0, halted=1. The state is sticky; only rst_n leaves it.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-DRAIN or mid-wait returns to RUN immediately (asynchronous). Counters clear.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum ctrl_state_e;
  - opcode constants R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR, HALT, so the decoder and this block share them;
  - the default DRAIN_CYCLES localparam.
- One combinational sub-module, hazard_detect, computes load_use from the ID/EX fields.

Test Plan:
- LW x5 in EX with ex_rd=5, ADD in ID with rs1=5, uses_rs1=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cnt 0->1; next cycle all enables 1.
- Same as above but ex_rd=0 -> no stall, stall_cnt stays 0.
- ex_redirect=1 together with load_use=1 -> ifid_flush=idex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- mem_req=1, mem_ready=0 for 3 cycles during a load_use -> pc_write=pipe_en=0 and no flush for those 3 cycles; the stall bubble is inserted on the 4th cycle.
- id_halt=1 in RUN, no waits -> DRAIN for 4 cycles, then halted=1 on cycle 5; a mem_wait of 2 cycles inside DRAIN delays halted by exactly 2 cycles.
- Reset pulse (rst_n=0 for 1 cycle) while HALTED -> halted=0 and state=RUN immediately; counters=0; enables return to 1 after release.
